// File: rtl/md_iter_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the Execute stage.
// Multiply uses a latency-padded full product; divide is a bit-serial restoring divider.
module md_iter_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opt,
    input  logic [WIDTH-1:0] v1,
    input  logic [WIDTH-1:0] v2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXCNT = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW     = $clog2(MAXCNT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] prod_q,    prod_d;
    logic [WIDTH:0]     rem_q,     rem_d;
    logic [WIDTH-1:0]   quo_q,     quo_d;
    logic [WIDTH-1:0]   dvsr_q,    dvsr_d;
    logic [WIDTH-1:0]   dvdRaw_q,  dvdRaw_d;
    logic               negQ_q,    negQ_d;
    logic               negR_q,    negR_d;
    logic               divZero_q, divZero_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [2*WIDTH-1:0] mulA, mulB;
    logic               signedDiv;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               fits;
    logic [WIDTH:0]     remNext;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   quoSigned, remSigned;

    // Operand preparation and one restoring-division step; quo_q doubles as the dividend shift register.
    always_comb begin
        mulA      = (opt == OP_MULT) ? {{WIDTH{v1[WIDTH-1]}}, v1} : {{WIDTH{1'b0}}, v1};
        mulB      = (opt == OP_MULT) ? {{WIDTH{v2[WIDTH-1]}}, v2} : {{WIDTH{1'b0}}, v2};
        signedDiv = (opt == OP_DIV);
        absA      = (signedDiv && v1[WIDTH-1]) ? -v1 : v1;
        absB      = (signedDiv && v2[WIDTH-1]) ? -v2 : v2;
        shifted   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff      = {1'b0, shifted} - {2'b00, dvsr_q};
        fits      = ~diff[WIDTH+1];
        remNext   = fits ? diff[WIDTH:0] : shifted;
        quoNext   = {quo_q[WIDTH-2:0], fits};
        quoSigned = negQ_q ? -quoNext : quoNext;
        remSigned = negR_q ? -remNext[WIDTH-1:0] : remNext[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        dvdRaw_d  = dvdRaw_q;
        negQ_d    = negQ_q;
        negR_d    = negR_q;
        divZero_d = divZero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (opt)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = mulA * mulB;
                            cnt_d   = MUL_LOAD;
                            state_d = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            rem_d     = '0;
                            quo_d     = absA;
                            dvsr_d    = absB;
                            dvdRaw_d  = v1;
                            negQ_d    = signedDiv && (v1[WIDTH-1] ^ v2[WIDTH-1]);
                            negR_d    = signedDiv && v1[WIDTH-1];
                            divZero_d = (v2 == '0);
                            cnt_d     = DIV_LOAD;
                            state_d   = DIV;
                        end
                        OP_MTHI: hi_d = v1;
                        OP_MTLO: lo_d = v1;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        hi_d    = prod_q[2*WIDTH-1:WIDTH];
                        lo_d    = prod_q[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DIV: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    rem_d = remNext;
                    quo_d = quoNext;
                    // The most-negative / -1 case needs no special handling: the magnitude quotient is already 2^(W-1).
                    if (cnt_q == CNT_ONE) begin
                        if (divZero_q) begin
                            hi_d = dvdRaw_q;
                            lo_d = '1;
                        end else begin
                            hi_d = remSigned;
                            lo_d = quoSigned;
                        end
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            dvdRaw_q  <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            dvdRaw_q  <= dvdRaw_d;
            negQ_q    <= negQ_d;
            negR_q    <= negR_d;
            divZero_q <= divZero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Self-checking bench for md_iter_unit: directed cases plus randomized ops
// compared against an arithmetic reference model of HI/LO.
module tb_md_iter_unit;

    localparam int W   = 32;
    localparam int MUL = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    opt;
    logic [W-1:0]  v1, v2;
    logic          cancel;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int assertCount = 0;
    int failCount   = 0;

    md_iter_unit #(.WIDTH(W), .MUL_CYCLES(MUL)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opt    (opt),
        .v1     (v1),
        .v2     (v2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; start is seen by the following posedge and we return at the next negedge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        opt   = op;
        v1    = a;
        v2    = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expLat, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n = 0;
        int doneWhileBusy = 0;
        while (busy === 1'b1 && n < 200) begin
            if (done === 1'b1) doneWhileBusy++;
            n++;
            @(negedge clk);
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(expLat));
        checkOutput({tag, " early done"}, 64'(doneWhileBusy), 64'd0);
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " hi"}, 64'(hi), 64'(eh));
        checkOutput({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    task automatic finishOp(input string tag, input int expLat, input logic [W-1:0] eh, input logic [W-1:0] el);
        waitDone(tag, expLat, eh, el);
        @(negedge clk);
        checkOutput({tag, " done width"}, 64'(done), 64'd0);
    endtask

    // Reference: plain 64-bit arithmetic, with divide-by-zero and overflow taken from the rules.
    function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] eh, output logic [W-1:0] el);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = 'x;
        el = 'x;
        case (op)
            3'b000: begin
                sp = sa * sb;
                up = sp;
                eh = up[63:32];
                el = up[31:0];
            end
            3'b001: begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            3'b010: begin
                if (b == 0) begin
                    eh = a;
                    el = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 0;
                    el = 32'h8000_0000;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    up = sq;
                    el = up[31:0];
                    up = sr;
                    eh = up[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    eh = a;
                    el = '1;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    initial begin
        logic [W-1:0] eh, el, modelHi, modelLo, a, b;
        logic [2:0]   op;
        int           doneSeen;

        reset  = 1'b1;
        start  = 1'b0;
        opt    = 3'b000;
        v1     = '0;
        v2     = '0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);

        applyStimulus(3'b000, 32'hFFFF_FFFE, 32'd3);
        finishOp("mult", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        applyStimulus(3'b001, 32'hFFFF_FFFE, 32'd3);
        finishOp("multu", MUL, 32'h0000_0002, 32'hFFFF_FFFA);

        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
        finishOp("div -7/2", W, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        applyStimulus(3'b011, 32'd7, 32'd2);
        finishOp("divu 7/2", W, 32'd1, 32'd3);
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'd1);
        finishOp("divu max/1", W, 32'd0, 32'hFFFF_FFFF);
        applyStimulus(3'b011, 32'h1234_5678, 32'd0);
        finishOp("divu by zero", W, 32'h1234_5678, 32'hFFFF_FFFF);
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        finishOp("div overflow", W, 32'd0, 32'h8000_0000);

        applyStimulus(3'b100, 32'h1111_1111, 32'd0);
        applyStimulus(3'b101, 32'h2222_2222, 32'd0);
        applyStimulus(3'b010, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("div cancel busy", 64'(busy), 64'd0);
        checkOutput("div cancel done", 64'(done), 64'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("div cancel late done", 64'(doneSeen), 64'd0);
        checkOutput("div cancel hi", 64'(hi), 64'h1111_1111);
        checkOutput("div cancel lo", 64'(lo), 64'h2222_2222);

        applyStimulus(3'b011, 32'd7, 32'd2);
        repeat (4) @(negedge clk);
        applyStimulus(3'b100, 32'h0000_AAAA, 32'd0);
        applyStimulus(3'b000, 32'd9, 32'd9);
        waitDone("start while busy", W - 6, 32'd1, 32'd3);
        @(negedge clk);

        applyStimulus(3'b100, 32'hDEAD_BEEF, 32'd0);
        checkOutput("mthi hi", 64'(hi), 64'hDEAD_BEEF);
        checkOutput("mthi busy", 64'(busy), 64'd0);
        checkOutput("mthi done", 64'(done), 64'd0);
        cancel = 1'b1;
        applyStimulus(3'b101, 32'h5555_5555, 32'd0);
        cancel = 1'b0;
        checkOutput("mtlo cancel lo", 64'(lo), 64'd3);

        applyStimulus(3'b000, 32'd6, 32'd7);
        repeat (MUL - 1) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("commit cancel busy", 64'(busy), 64'd0);
        checkOutput("commit cancel done", 64'(done), 64'd0);
        checkOutput("commit cancel hi", 64'(hi), 64'hDEAD_BEEF);
        checkOutput("commit cancel lo", 64'(lo), 64'd3);

        modelHi = 32'h0BAD_F00D;
        modelLo = 32'hCAFE_0001;
        applyStimulus(3'b100, modelHi, 32'd0);
        applyStimulus(3'b101, modelLo, 32'd0);
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            applyStimulus(op, a, b);
            if (op <= 3'b011) begin
                refModel(op, a, b, eh, el);
                modelHi = eh;
                modelLo = el;
                finishOp($sformatf("rand%0d op%0d", i, op), (op <= 3'b001) ? MUL : W, modelHi, modelLo);
            end else begin
                if (op == 3'b100) modelHi = a;
                if (op == 3'b101) modelLo = a;
                checkOutput($sformatf("rand%0d op%0d busy", i, op), 64'(busy), 64'd0);
                checkOutput($sformatf("rand%0d op%0d hi", i, op), 64'(hi), 64'(modelHi));
                checkOutput($sformatf("rand%0d op%0d lo", i, op), 64'(lo), 64'(modelLo));
            end
        end

        applyStimulus(3'b000, 32'd1234, 32'd5678);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset done", 64'(done), 64'd0);
        checkOutput("mid reset hi", 64'(hi), 64'd0);
        checkOutput("mid reset lo", 64'(lo), 64'd0);
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
        end
        checkOutput("mid reset late done", 64'(doneSeen), 64'd0);

        applyStimulus(3'b001, 32'd1000, 32'd3000);
        waitDone("b2b first", MUL, 32'd0, 32'd3_000_000);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("b2b second busy", 64'(busy), 64'd1);
        checkOutput("b2b second done", 64'(done), 64'd0);
        finishOp("b2b second", MUL, 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
